// File: rtl/rptr_empty_ctrl.sv
// rptr_empty_ctrl: read-side pointer, Gray publish and empty/almost-empty/level/underflow flags for a dual-clock FIFO.
module rptr_empty_ctrl #(
    parameter int ADDR_SIZE = 4,
    parameter int AE_THRESH = 2
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 rinc,
    input  logic [ADDR_SIZE:0]   rq2_wptr,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE:0]   rptr,
    output logic                 rempty,
    output logic                 raempty,
    output logic [ADDR_SIZE:0]   rlevel,
    output logic                 rerr
);
    localparam logic [ADDR_SIZE:0] AE = AE_THRESH[ADDR_SIZE:0];
    logic [ADDR_SIZE:0] rbin, rbinnext, rgraynext, wbin_s, lvl_next;
    logic               rd_ok;
    assign rd_ok     = rinc & ~rempty;
    assign rbinnext  = rbin + {{ADDR_SIZE{1'b0}}, rd_ok};
    assign rgraynext = (rbinnext >> 1) ^ rbinnext;
    assign lvl_next  = wbin_s - rbinnext;
    assign raddr     = rbin[ADDR_SIZE-1:0];
    // Gray-to-binary: each bit is the XOR of all Gray bits at or above it
    always_comb begin
        wbin_s = '0;
        for (int i = 0; i <= ADDR_SIZE; i++)
            wbin_s[i] = ^(rq2_wptr >> i);
    end
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin    <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            raempty <= 1'b1;
            rlevel  <= '0;
            rerr    <= 1'b0;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            rempty  <= (rgraynext == rq2_wptr);
            raempty <= (lvl_next <= AE);
            rlevel  <= lvl_next;
            rerr    <= rerr | (rinc & rempty);
        end
    end
endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// tb_rptr_empty_ctrl: randomized and directed checks of rptr_empty_ctrl against a read/write-count model.
module tb_rptr_empty_ctrl;
    localparam int AE = 2;
    logic        rclk = 1'b0, rrst = 1'b0, rinc = 1'b0, clk_en = 1'b0;
    logic [4:0]  rq2_wptr = '0;
    logic [3:0]  raddr;
    logic [4:0]  rptr, rlevel;
    logic        rempty, raempty, rerr;
    logic [16:0] obs;
    int          n_chk = 0, n_fail = 0;
    int          rp, wp, m_lvl;
    logic        m_emp, m_ae, m_err;

    rptr_empty_ctrl #(.ADDR_SIZE(4), .AE_THRESH(AE)) dut (
        .rclk(rclk), .rrst(rrst), .rinc(rinc), .rq2_wptr(rq2_wptr),
        .raddr(raddr), .rptr(rptr), .rempty(rempty), .raempty(raempty),
        .rlevel(rlevel), .rerr(rerr)
    );

    always #5 if (clk_en) rclk = ~rclk;
    assign obs = {rptr, raddr, rempty, raempty, rlevel, rerr};

    function automatic logic [4:0] gray(input int b);
        logic [4:0] x;
        x = b[4:0];
        return x ^ (x >> 1);
    endfunction

    // Expected outputs from counts: reads done, level = writes seen - reads
    function automatic logic [16:0] expv();
        logic [4:0] r, l;
        r = rp[4:0];
        l = m_lvl[4:0];
        return {gray(rp), r[3:0], m_emp, m_ae, l, m_err};
    endfunction

    task automatic model_reset();
        rp = 0; wp = 0; m_lvl = 0; m_emp = 1'b1; m_ae = 1'b1; m_err = 1'b0;
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        #1;
        model_reset();
        rq2_wptr = '0;
        rinc = 1'b0;
        rrst = 1'b0;
        #1;
    endtask

    task automatic cyc(input logic ri, input int w);
        wp = w;
        rinc = ri;
        rq2_wptr = gray(w);
        @(posedge rclk);
        #1;
        if (ri) begin
            if (m_emp) m_err = 1'b1;
            else rp++;
        end
        m_lvl = (wp - rp) & 31;
        m_emp = (m_lvl == 0);
        m_ae  = (m_lvl <= AE);
    endtask

    task automatic test_reset();
        rrst = 1'b1;
        #1;
        model_reset();
        n_chk++;
        if (obs !== expv()) begin n_fail++; $display("FAIL reset_async: got %h expected %h", obs, expv()); end
        n_chk++;
        if ({rempty, raempty, rptr, rlevel, rerr} !== 13'b1_1_00000_00000_0) begin
            n_fail++; $display("FAIL reset_values: got %b expected 1100000000000", {rempty, raempty, rptr, rlevel, rerr});
        end
        rrst = 1'b0;
        #1;
        n_chk++;
        if (obs !== expv()) begin n_fail++; $display("FAIL reset_release: got %h expected %h", obs, expv()); end
    endtask

    task automatic test_fill_drain();
        cyc(1'b0, 5);
        n_chk++;
        if ({rempty, raempty, rlevel} !== 7'b0_0_00101) begin
            n_fail++; $display("FAIL fill_flags: got %b expected 0000101", {rempty, raempty, rlevel});
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 5);
            n_chk++;
            if (obs !== expv()) begin n_fail++; $display("FAIL drain_step%0d: got %h expected %h", i, obs, expv()); end
        end
        n_chk++;
        if ({rempty, raddr, rlevel} !== {1'b1, 4'd5, 5'd0}) begin
            n_fail++; $display("FAIL drain_last: got %b expected 1010100000", {rempty, raddr, rlevel});
        end
    endtask

    task automatic test_wrap();
        logic [4:0] prev;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, wp + 1);
            n_chk++;
            if (obs !== expv()) begin n_fail++; $display("FAIL wrap_write%0d: got %h expected %h", i, obs, expv()); end
            prev = rptr;
            cyc(1'b1, wp);
            n_chk++;
            if (obs !== expv()) begin n_fail++; $display("FAIL wrap_read%0d: got %h expected %h", i, obs, expv()); end
            n_chk++;
            if ($countones(prev ^ rptr) != 1) begin
                n_fail++; $display("FAIL wrap_gray%0d: got %b->%b expected one bit change", i, prev, rptr);
            end
        end
    endtask

    task automatic test_underflow();
        logic [4:0] held;
        held = rptr;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, wp);
            n_chk++;
            if (obs !== expv()) begin n_fail++; $display("FAIL underflow%0d: got %h expected %h", i, obs, expv()); end
            n_chk++;
            if ({rptr, rerr} !== {held, 1'b1}) begin
                n_fail++; $display("FAIL underflow_hold%0d: got %b expected %b", i, {rptr, rerr}, {held, 1'b1});
            end
        end
        cyc(1'b0, wp);
        n_chk++;
        if (rerr !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky: got %b expected 1", rerr); end
        do_reset();
        n_chk++;
        if (obs !== expv()) begin n_fail++; $display("FAIL underflow_clear: got %h expected %h", obs, expv()); end
    endtask

    task automatic test_full_simul();
        cyc(1'b0, 16);
        n_chk++;
        if ({rlevel, rempty} !== {5'd16, 1'b0}) begin
            n_fail++; $display("FAIL full_level: got %b expected 100000", {rlevel, rempty});
        end
        cyc(1'b1, 17);
        n_chk++;
        if (rlevel !== 5'd16) begin n_fail++; $display("FAIL simul_level: got %0d expected 16", rlevel); end
        n_chk++;
        if (obs !== expv()) begin n_fail++; $display("FAIL simul_all: got %h expected %h", obs, expv()); end
    endtask

    task automatic test_reset_mid();
        while (m_lvl > 7) cyc(1'b1, wp);
        n_chk++;
        if (rlevel !== 5'd7) begin n_fail++; $display("FAIL mid_level: got %0d expected 7", rlevel); end
        rinc = 1'b1;
        rrst = 1'b1;
        #1;
        model_reset();
        n_chk++;
        if (obs !== expv()) begin n_fail++; $display("FAIL mid_reset: got %h expected %h", obs, expv()); end
        rrst = 1'b0;
        cyc(1'b0, 0);
        n_chk++;
        if ({rempty, rptr} !== 6'b1_00000) begin
            n_fail++; $display("FAIL mid_release: got %b expected 100000", {rempty, rptr});
        end
    endtask

    task automatic test_random();
        int adv;
        logic ri;
        for (int i = 0; i < 400; i++) begin
            ri = 1'($urandom_range(0, 1));
            adv = ((wp - rp) < 16 && $urandom_range(0, 2) != 0) ? 1 : 0;
            cyc(ri, wp + adv);
            n_chk++;
            if (obs !== expv()) begin n_fail++; $display("FAIL random%0d: got %h expected %h", i, obs, expv()); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        clk_en = 1'b1;
        test_fill_drain();
        test_wrap();
        test_underflow();
        test_full_simul();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rptr_empty_ctrl.md
# rptr_empty_ctrl

Parametrised read-side controller for the dual-clock FIFO. It keeps the binary read pointer and publishes it as Gray code for the write domain. From the already-synchronised write pointer it derives registered `rempty` and `raempty` (almost-empty) flags, a fill level, and a sticky underflow error. It sits in the read clock domain between the two-flop synchroniser (which supplies `rq2_wptr`) and the FIFO memory read port (which consumes `raddr`).

## Interface
- `ADDR_SIZE`, 4: memory address width. Depth = 2^ADDR_SIZE. Pointers are ADDR_SIZE+1 bits.
- `AE_THRESH`, 2: almost-empty threshold. `raempty` asserts when level <= AE_THRESH. Legal range 0..2^ADDR_SIZE-1.

Ports:
- `rclk` input 1: read clock. All state updates on the rising edge.
- `rrst` input 1: asynchronous, active-high reset.
- `rinc` input 1: read request for this cycle.
- `rq2_wptr` input ADDR_SIZE+1: write pointer, Gray code, already synchronised to `rclk`.
- `raddr` output ADDR_SIZE: memory read address, equal to the low ADDR_SIZE bits of the binary read pointer.
- `rptr` output ADDR_SIZE+1: registered Gray read pointer, sent to the write-domain synchroniser.
- `rempty` output 1: registered empty flag.
- `raempty` output 1: registered almost-empty flag.
- `rlevel` output ADDR_SIZE+1: registered fill level, 0..2^ADDR_SIZE, as seen from the read side.
- `rerr` output 1: sticky underflow flag.

## Operation
- State registers: `rbin` (binary, ADDR_SIZE+1 bits), `rptr` (Gray), `rempty`, `raempty`, `rlevel`, `rerr`.
- Accepted read: `rd_ok = rinc & ~rempty`.
- Next pointers:
  - `rbinnext = rbin + rd_ok`, modulo 2^(ADDR_SIZE+1), so it wraps naturally with no special case.
  - `rgraynext = (rbinnext >> 1) ^ rbinnext`.
- Write pointer in binary: `wbin_s` = Gray-to-binary of `rq2_wptr`, a combinational XOR prefix from the MSB down.
- Next level: `lvl_next = wbin_s - rbinnext`, modulo 2^(ADDR_SIZE+1).
- Per-edge register updates:
  - `rbin <= rbinnext`, `rptr <= rgraynext`.
  - `rempty <= (rgraynext == rq2_wptr)`. This must agree with `lvl_next == 0`.
  - `raempty <= (lvl_next <= AE_THRESH)`.
  - `rlevel <= lvl_next`.
  - `rerr <= rerr | (rinc & rempty)`.
- Underflow: `rinc` while `rempty` = 1 does not move the pointer and sets `rerr`. `rerr` clears only on `rrst`.
- Pointer changes are ±1 per cycle on `rbin`, so `rptr` changes by exactly one bit per accepted read. No other `rptr` transitions are allowed.
- The level is pessimistic, because `rq2_wptr` lags the true write pointer by the synchroniser delay. `rempty` may stay high after writes, but must never be low while the FIFO is truly empty.

## Timing
- Reset values, applied immediately on `rrst` rising, with no clock needed:
  - `rbin`, `rptr`, `raddr`, `rlevel`, `rerr` = 0.
  - `rempty` = 1, `raempty` = 1.
- Reset may assert mid-operation. It abandons any in-flight read, and all outputs go straight to their reset values. The first edge after `rrst` falls is a normal cycle.
- `raddr` and `rptr` update 1 cycle after an accepted `rinc` edge. Data at the old `raddr` is the word consumed by that read.
- Flag latency: `rempty`, `raempty` and `rlevel` reflect `rq2_wptr` sampled at the same edge, i.e. 1 `rclk` after `rq2_wptr` changes.
- The last-word read clears the level and sets the flag on the same edge:
  - `rempty` rises on the edge that accepts the read bringing `lvl_next` to 0.
  - The consumer can therefore issue back-to-back `rinc` with no bubble before empty.
- Simultaneous `rq2_wptr` advance and accepted read on the same edge: the level is unchanged and the flags are recomputed from both next values.
- Full level: `rlevel` = 2^ADDR_SIZE is legal. The MSB of `rlevel` is set only in that case.

## Test plan
- Reset check: pulse `rrst` with `rclk` stopped.
  - Required: `rempty`=1, `raempty`=1, `rptr`=0, `rlevel`=0, `rerr`=0 immediately.
- Fill and drain, ADDR_SIZE=4, AE_THRESH=2. Step `rq2_wptr` to Gray(5)=5'b00111.
  - Next edge: `rempty`=0, `raempty`=0, `rlevel`=5.
  - Hold `rinc`=1: `rlevel` goes 4, 3, 2.
  - `raempty` rises on the edge where the level becomes 2.
  - `rempty` rises on the edge where the level becomes 0, and `raddr`=5 then.
- Wrap-around: run 40 single-word write/read pairs.
  - `rbin` passes 31→0, `rptr` passes 5'b10000→5'b00000.
  - Every `rptr` change is a single-bit change.
  - `rempty` is correct at each step.
- Underflow: with the FIFO empty, assert `rinc` for 3 cycles.
  - `rptr` stays constant, `rerr`=1 after the first edge and remains 1.
  - Only `rrst` clears `rerr`.
- Full and simultaneous events: set `rq2_wptr` to Gray(16).
  - `rlevel`=16, `rempty`=0.
  - Advance `rq2_wptr` by 1 and assert `rinc` on the same edge: `rlevel` stays 16.
- Reset mid-drain: assert `rrst` with `rlevel`=7 and `rinc`=1.
  - All outputs go to reset values asynchronously.
  - After release, with `rq2_wptr`=0: `rempty`=1 and `rptr`=0.
